// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file.
//
// Sits between decode/issue (read ports, busy-set) and writeback (write
// ports). Register 0 is hardwired to zero. Every read port bypasses the
// value of any same-cycle write to its address, and a per-register busy
// scoreboard tracks outstanding producers for the issue stage. After reset
// an optional sequencer sweeps registers 1..NREGS-1 to zero, one per cycle.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous, active-high reset
//   ready     high when reads/writes are accepted (READY state)
//   we        per-write-port enable                  [NWR]
//   waddr     write addresses, port k at [k*AW +: AW]
//   wdata     write data, port k at [k*XLEN +: XLEN]
//   re        per-read-port enable                   [NRD]
//   raddr     read addresses, port j at [j*AW +: AW]
//   rdata     combinational read data, port j at [j*XLEN +: XLEN]
//   rbusy     combinational busy bit per read port   [NRD]
//   set_busy  mark set_addr as having a pending producer
//   set_addr  register to mark busy
module regfile_mp #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int NRD        = 2,
  parameter int NWR        = 2,
  parameter int CLR_ON_RST = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                set_busy,
  input  logic [AW-1:0]       set_addr
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic              active;

  // Everything externally visible is gated by rst as well as the state, so
  // the outputs are defined during the reset cycle itself.
  assign active = !rst && (state_q == S_READY);
  assign ready  = active;

  // Sequencer: CLEAR walks ptr from 1 up to NREGS-1, then parks in READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(NREGS - 1)) state_d = S_READY;
    end
  end

  // Scoreboard: writes retire their producer, then a new issue (set_busy)
  // overrides so a same-cycle set on the same register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (active) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*AW +: AW] != '0)) busy_d[waddr[k*AW +: AW]] = 1'b0;
      end
      if (set_busy && (set_addr != '0)) busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_READY;
      ptr_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Register array has no reset; it is zeroed only by the CLEAR sweep.
  // Later write ports are assigned last, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_CLEAR)) begin
      regs_q[ptr_q] <= '0;
    end else if (active) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*AW +: AW] != '0)) regs_q[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  // Read ports with same-cycle write bypass. A bypassed value is not busy
  // unless set_busy re-marks the same register in this cycle.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] val;
      logic            hit;
      ra  = raddr[j*AW +: AW];
      val = '0;
      hit = 1'b0;
      if (active && re[j] && (ra != '0)) begin
        val = regs_q[ra];
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (waddr[k*AW +: AW] == ra)) begin
            val = wdata[k*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
        rdata[j*XLEN +: XLEN] = val;
        rbusy[j] = hit ? (set_busy && (set_addr == ra)) : busy_q[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- bench for regfile_mp.
//   dut  : default parameters (32x32, 2R/2W, CLR_ON_RST=1)
//   dut3 : same geometry, CLR_ON_RST=0, shares dut's data inputs
//   dut2 : 64x64, 4R/3W, CLR_ON_RST=1
module tb_regfile_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // dut / dut3 shared stimulus
  logic        rst, rst3;
  logic [1:0]  we, re;
  logic [9:0]  waddr, raddr;
  logic [63:0] wdata;
  logic        set_busy;
  logic [4:0]  set_addr;
  logic        ready, ready3;
  logic [63:0] rdata, rdata3;
  logic [1:0]  rbusy, rbusy3;

  // dut2 stimulus
  logic         rst2;
  logic [2:0]   we2;
  logic [17:0]  waddr2;
  logic [191:0] wdata2;
  logic [3:0]   re2;
  logic [23:0]  raddr2;
  logic         set_busy2;
  logic [5:0]   set_addr2;
  logic         ready2;
  logic [255:0] rdata2;
  logic [3:0]   rbusy2;

  regfile_mp dut (
    .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .set_busy(set_busy), .set_addr(set_addr));

  regfile_mp #(.CLR_ON_RST(0)) dut3 (
    .clk(clk), .rst(rst3), .ready(ready3), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata3), .rbusy(rbusy3),
    .set_busy(set_busy), .set_addr(set_addr));

  regfile_mp #(.XLEN(64), .NREGS(64), .NRD(4), .NWR(3)) dut2 (
    .clk(clk), .rst(rst2), .ready(ready2), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .re(re2), .raddr(raddr2), .rdata(rdata2), .rbusy(rbusy2),
    .set_busy(set_busy2), .set_addr(set_addr2));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sa;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } exp_t;

  exp_t expq[$];

  function automatic vec_t mk(logic [1:0] we_, logic [4:0] wa0_, logic [31:0] wd0_,
                              logic [4:0] wa1_, logic [31:0] wd1_, logic [1:0] re_,
                              logic [4:0] ra0_, logic [4:0] ra1_, logic sb_, logic [4:0] sa_,
                              logic [31:0] e0_, logic [31:0] e1_, logic [1:0] eb_);
    vec_t v;
    v.we = we_; v.wa0 = wa0_; v.wd0 = wd0_; v.wa1 = wa1_; v.wd1 = wd1_;
    v.re = re_; v.ra0 = ra0_; v.ra1 = ra1_; v.sb = sb_; v.sa = sa_;
    v.e0 = e0_; v.e1 = e1_; v.eb = eb_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    set_busy = 1'b0; set_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    we = v.we; waddr = {v.wa1, v.wa0}; wdata = {v.wd1, v.wd0};
    re = v.re; raddr = {v.ra1, v.ra0}; set_busy = v.sb; set_addr = v.sa;
    e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb;
    expq.push_back(e);
  endtask

  // Counts cycles with ready low after rst drops; also notes any nonzero
  // read output seen while not ready. Bounded so a stuck sweep still ends.
  task automatic wait_ready(input int sel, output int n, output bit leak);
    n = 0;
    leak = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sel == 2) begin
        if (ready2) return;
        if (rdata2 != '0 || rbusy2 != '0) leak = 1'b1;
      end else begin
        if (ready) return;
        if (rdata != '0 || rbusy != '0) leak = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs[17];

  initial begin
    int  n;
    bit  leak;
    exp_t e;

    vecs[0]  = mk(2'b01,  3, 32'h1234,  0, 0,        2'b11,  3,  0, 0,  0, 32'h1234, 32'h0,    2'b00);
    vecs[1]  = mk(2'b00,  0, 0,         0, 0,        2'b01,  3,  3, 0,  0, 32'h1234, 32'h0,    2'b00);
    vecs[2]  = mk(2'b01,  0, 32'hFFFF,  0, 0,        2'b11,  0,  3, 0,  0, 32'h0,    32'h1234, 2'b00);
    vecs[3]  = mk(2'b11,  7, 32'hAAAA,  7, 32'hBBBB, 2'b11,  7,  7, 0,  0, 32'hBBBB, 32'hBBBB, 2'b00);
    vecs[4]  = mk(2'b00,  0, 0,         0, 0,        2'b11,  7,  3, 0,  0, 32'hBBBB, 32'h1234, 2'b00);
    vecs[5]  = mk(2'b00,  0, 0,         0, 0,        2'b11,  9,  0, 1,  9, 32'h0,    32'h0,    2'b00);
    vecs[6]  = mk(2'b00,  0, 0,         0, 0,        2'b11,  9,  9, 0,  0, 32'h0,    32'h0,    2'b11);
    vecs[7]  = mk(2'b10,  0, 0,         9, 32'h55,   2'b11,  9,  9, 0,  0, 32'h55,   32'h55,   2'b00);
    vecs[8]  = mk(2'b00,  0, 0,         0, 0,        2'b11,  9,  0, 0,  0, 32'h55,   32'h0,    2'b00);
    vecs[9]  = mk(2'b01,  9, 32'h66,    0, 0,        2'b11,  9,  9, 1,  9, 32'h66,   32'h66,   2'b11);
    vecs[10] = mk(2'b00,  0, 0,         0, 0,        2'b11,  9,  9, 0,  0, 32'h66,   32'h66,   2'b11);
    vecs[11] = mk(2'b00,  0, 0,         0, 0,        2'b11,  0,  9, 1,  0, 32'h0,    32'h66,   2'b10);
    vecs[12] = mk(2'b00,  0, 0,         0, 0,        2'b10,  9,  7, 0,  0, 32'h0,    32'hBBBB, 2'b00);
    vecs[13] = mk(2'b11, 12, 32'h11,   13, 32'h22,   2'b11, 12, 13, 0,  0, 32'h11,   32'h22,   2'b00);
    vecs[14] = mk(2'b01,  9, 32'h77,    0, 0,        2'b11,  9,  0, 0,  0, 32'h77,   32'h0,    2'b00);
    vecs[15] = mk(2'b00,  0, 0,         0, 0,        2'b11,  9, 12, 0,  0, 32'h77,   32'h11,   2'b00);
    vecs[16] = mk(2'b10,  0, 0,        13, 32'h33,   2'b11, 13, 12, 1, 13, 32'h33,   32'h11,   2'b01);

    rst = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
    idle();
    we2 = '0; waddr2 = '0; wdata2 = '0; re2 = '0; raddr2 = '0;
    set_busy2 = 1'b0; set_addr2 = '0;
    repeat (2) tick();

    // Outputs forced low during reset even with an active bypass write.
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h55};
    re = 2'b11; raddr = {5'd3, 5'd3}; set_busy = 1'b1; set_addr = 5'd3;
    @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rbusy", {62'b0, rbusy}, 64'd0);
    chk("rst_ready3", {63'b0, ready3}, 64'd0);

    // CLR_ON_RST=0: ready right after reset, contents retained across reset.
    rst3 = 1'b0; set_busy = 1'b0;
    @(negedge clk);
    chk("nclr_ready", {63'b0, ready3}, 64'd1);
    chk("nclr_bypass", {32'b0, rdata3[31:0]}, 64'h55);
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd3};
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    @(negedge clk);
    chk("nclr_ready_again", {63'b0, ready3}, 64'd1);
    chk("nclr_kept", {32'b0, rdata3[31:0]}, 64'h55);
    @(posedge clk); #1;
    idle();

    // Initial sweep on dut.
    rst = 1'b0;
    wait_ready(1, n, leak);
    chk("sweep0_len", 64'(n), 64'd31);
    @(posedge clk); #1;

    // Table-driven single-cycle vectors through the scoreboard queue.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      e = expq.pop_front();
      chk($sformatf("v%0d_rd0", i), {32'b0, rdata[31:0]}, {32'b0, e.e0});
      chk($sformatf("v%0d_rd1", i), {32'b0, rdata[63:32]}, {32'b0, e.e1});
      chk($sformatf("v%0d_rbusy", i), {62'b0, rbusy}, {62'b0, e.eb});
      chk($sformatf("v%0d_ready", i), {63'b0, ready}, 64'd1);
      @(posedge clk); #1;
    end
    idle();

    // Preload then full reset sweep clears it.
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD};
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd5};
    @(negedge clk);
    chk("preload_x5", {32'b0, rdata[31:0]}, 64'hDEAD);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(1, n, leak);
    chk("sweep1_len", 64'(n), 64'd31);
    re = 2'b11; raddr = {5'd3, 5'd5};
    #1;
    chk("sweep1_x5", {32'b0, rdata[31:0]}, 64'd0);
    chk("sweep1_x3", {32'b0, rdata[63:32]}, 64'd0);
    @(posedge clk); #1;
    idle();

    // Reset mid-sweep restarts it; writes and set_busy during CLEAR ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hCAFE};
    set_busy = 1'b1; set_addr = 5'd4;
    re = 2'b11; raddr = {5'd4, 5'd4};
    wait_ready(1, n, leak);
    idle();
    re = 2'b11; raddr = {5'd4, 5'd4};
    chk("midrst_len", 64'(n), 64'd31);
    chk("midrst_clear_quiet", {63'b0, leak}, 64'd0);
    #1;
    chk("midrst_x4", {32'b0, rdata[31:0]}, 64'd0);
    chk("midrst_x4_busy", {62'b0, rbusy}, 64'd0);
    @(posedge clk); #1;
    idle();

    // Wide configuration: 63-cycle sweep and all-port bypass.
    rst2 = 1'b0;
    wait_ready(2, n, leak);
    chk("big_sweep_len", 64'(n), 64'd63);
    @(posedge clk); #1;
    we2 = 3'b111;
    waddr2 = {6'd30, 6'd20, 6'd10};
    wdata2 = {64'hCCCC_0000_0000_001E, 64'hBBBB_0000_0000_0014, 64'hAAAA_0000_0000_000A};
    re2 = 4'b1111;
    raddr2 = {6'd10, 6'd30, 6'd20, 6'd10};
    @(negedge clk);
    chk("big_byp_p0", rdata2[63:0],    64'hAAAA_0000_0000_000A);
    chk("big_byp_p1", rdata2[127:64],  64'hBBBB_0000_0000_0014);
    chk("big_byp_p2", rdata2[191:128], 64'hCCCC_0000_0000_001E);
    chk("big_byp_p3", rdata2[255:192], 64'hAAAA_0000_0000_000A);
    @(posedge clk); #1;
    waddr2 = {6'd40, 6'd41, 6'd40};
    wdata2 = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0BAD};
    raddr2 = {6'd30, 6'd10, 6'd41, 6'd40};
    @(negedge clk);
    chk("big_conf_byp", rdata2[63:0],    64'h2222_2222_2222_2222);
    chk("big_p1_byp",   rdata2[127:64],  64'h1111_1111_1111_1111);
    chk("big_arr_x10",  rdata2[191:128], 64'hAAAA_0000_0000_000A);
    chk("big_arr_x30",  rdata2[255:192], 64'hCCCC_0000_0000_001E);
    @(posedge clk); #1;
    we2 = '0;
    @(negedge clk);
    chk("big_conf_arr", rdata2[63:0],   64'h2222_2222_2222_2222);
    chk("big_x41_arr",  rdata2[127:64], 64'h1111_1111_1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
